// File: rtl/jk_pkg.sv
// Shared encodings and next-state function for the JK command sequencer.
// jk_next() is used by the checker and matches the behaviour of jk_ff.
package jk_pkg;

  typedef enum logic [1:0] {
    OP_HOLD   = 2'b00,
    OP_CLEAR  = 2'b01,
    OP_SET    = 2'b10,
    OP_TOGGLE = 2'b11
  } op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic jk_next(input logic q, input logic j, input logic k);
    case ({j, k})
      2'b00:   return q;
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return ~q;
    endcase
  endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Synchronous command FIFO. Read data is shown combinationally from the head entry.
// The pointers carry an extra wrap bit so that full and empty can be told apart.
module jk_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage holds data only and is never reset.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Drives j/k from queued JK commands and checks the fed-back q against a shadow flip-flop.
// Every command is driven for cnt+1 cycles, and commands follow one another with no HOLD bubble.
module jk_cmd_sequencer
  import jk_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_op_i,
  input  logic [CNT_W-1:0] cmd_cnt_i,
  output logic             j_o,
  output logic             k_o,
  input  logic             q_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [7:0]       err_cnt_o
);

  localparam int FW = 2 + CNT_W;

  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [FW-1:0]    fifo_dout;
  logic [1:0]       head_op;
  logic [CNT_W-1:0] head_cnt;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] rem_nxt;
  logic             j_nxt;
  logic             k_nxt;
  logic             done_nxt;
  logic             exp_q;
  logic             synced;

  assign push        = cmd_valid_i && !fifo_full;
  assign cmd_ready_o = !fifo_full;
  assign busy_o      = (state == ST_RUN) || !fifo_empty;
  assign head_op     = fifo_dout[FW-1:CNT_W];
  assign head_cnt    = fifo_dout[CNT_W-1:0];

  jk_cmd_fifo #(.DEPTH(DEPTH), .W(FW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   ({cmd_op_i, cmd_cnt_i}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    j_nxt     = j_o;
    k_nxt     = k_o;
    pop       = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        j_nxt = 1'b0;
        k_nxt = 1'b0;
        if (!fifo_empty) begin
          pop            = 1'b1;
          {j_nxt, k_nxt} = head_op;
          rem_nxt        = head_cnt;
          state_nxt      = ST_RUN;
        end
      end
      default: begin
        if (rem == '0) begin
          done_nxt = 1'b1;
          // On the last drive cycle the next command is loaded directly, so no HOLD cycle is inserted.
          if (!fifo_empty) begin
            pop            = 1'b1;
            {j_nxt, k_nxt} = head_op;
            rem_nxt        = head_cnt;
          end else begin
            j_nxt     = 1'b0;
            k_nxt     = 1'b0;
            state_nxt = ST_IDLE;
          end
        end else begin
          rem_nxt = rem - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      j_o       <= 1'b0;
      k_o       <= 1'b0;
      done_o    <= 1'b0;
      exp_q     <= 1'b0;
      synced    <= 1'b0;
      err_o     <= 1'b0;
      err_cnt_o <= '0;
    end else begin
      state  <= state_nxt;
      j_o    <= j_nxt;
      k_o    <= k_nxt;
      done_o <= done_nxt;
      // The shadow model samples j/k at the same edge as jk_ff does.
      exp_q  <= jk_next(exp_q, j_o, k_o);
      synced <= synced | (j_o ^ k_o);
      err_o  <= synced && (q_i != exp_q);
      if (err_o && (err_cnt_o != 8'hFF)) err_cnt_o <= err_cnt_o + 1'b1;
    end
  end

  // The remaining-count register is only read in RUN, after it has been loaded.
  always_ff @(posedge clk) begin
    rem <= rem_nxt;
  end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed bench: jk_cmd_sequencer drives a behavioural jk_ff, whose q is fed back (optionally inverted).
module tb_jk_cmd_sequencer;
  import jk_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_cnt = 8'd0;
  logic       j, k, q, q_fb;
  logic       busy, done, err;
  logic [7:0] err_cnt;
  logic       force_inv = 1'b0;

  int total = 0;
  int bad = 0;
  int done_seen = 0;
  int err_seen = 0;
  logic [1:0] jk_log [$];
  logic [1:0] ops3 [6] = '{OP_SET, OP_TOGGLE, OP_CLEAR, OP_TOGGLE, OP_SET, OP_TOGGLE};

  always #5 clk = ~clk;

  // Behavioural jk_ff downstream of the sequencer.
  always @(posedge clk) begin
    if (reset) q <= 1'b0;
    else case ({j, k})
      2'b01:   q <= 1'b0;
      2'b10:   q <= 1'b1;
      2'b11:   q <= ~q;
      default: q <= q;
    endcase
  end
  assign q_fb = q ^ force_inv;

  always @(negedge clk) begin
    jk_log.push_back({j, k});
    if (done) done_seen <= done_seen + 1;
    if (err)  err_seen  <= err_seen + 1;
  end

  jk_cmd_sequencer #(.DEPTH(4), .CNT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_cnt_i   (cmd_cnt),
    .j_o         (j),
    .k_o         (k),
    .q_i         (q_fb),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .err_cnt_o   (err_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int d0, e0, base, first, acc, drop, n, cnt10;
    logic rdy, ok;

    // Reset state
    step(); step();
    chk("rst_ready", cmd_ready, 1);
    chk("rst_j", j, 0);
    chk("rst_k", k, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    reset = 1'b0;

    // 1: single SET cnt=0
    d0 = done_seen;
    cmd_valid = 1'b1; cmd_op = OP_SET; cmd_cnt = 8'd0;
    step();
    cmd_valid = 1'b0;
    chk("t1_j_before", j, 0);
    chk("t1_busy", busy, 1);
    step();
    chk("t1_j_drive", j, 1);
    chk("t1_k_drive", k, 0);
    step();
    chk("t1_j_after", j, 0);
    chk("t1_q", q, 1);
    chk("t1_done", done, 1);
    step();
    chk("t1_done_low", done, 0);
    chk("t1_err_cnt", err_cnt, 0);
    chk("t1_done_count", done_seen - d0, 1);

    // 2: CLEAR cnt=0 then TOGGLE cnt=3 back to back
    d0 = done_seen;
    cmd_valid = 1'b1; cmd_op = OP_CLEAR; cmd_cnt = 8'd0;
    step();
    cmd_op = OP_TOGGLE; cmd_cnt = 8'd3;
    step();
    cmd_valid = 1'b0;
    chk("t2_clear_k", k, 1);
    chk("t2_clear_j", j, 0);
    step();
    chk("t2_q0", q, 0);
    chk("t2_toggle_nobubble", {j, k}, 2'b11);
    step(); chk("t2_q1", q, 1);
    step(); chk("t2_q2", q, 0);
    step(); chk("t2_q3", q, 1);
    step(); chk("t2_q4", q, 0);
    chk("t2_hold_after", {j, k}, 2'b00);
    step();
    chk("t2_done_count", done_seen - d0, 2);
    chk("t2_err_cnt", err_cnt, 0);

    // 3: six commands cnt=7 with valid held; the first leaves the FIFO at once, so the fifth fills it
    d0 = done_seen; base = jk_log.size(); acc = 0; drop = -1; n = 0;
    cmd_valid = 1'b1; cmd_cnt = 8'd7;
    while (acc < 6 && n < 200) begin
      cmd_op = ops3[acc];
      rdy = cmd_ready;
      if (!rdy && drop < 0) drop = acc;
      step();
      if (rdy) acc++;
      n++;
    end
    cmd_valid = 1'b0;
    chk("t3_accepts", acc, 6);
    chk("t3_ready_drop_after", drop, 5);
    n = 0;
    while (busy && n < 200) begin step(); n++; end
    chk("t3_drain_timeout", busy, 0);
    step(); step();
    first = base;
    while (first < jk_log.size() - 1 && jk_log[first] == 2'b00) first++;
    for (int m = 0; m < 6; m++) begin
      ok = 1'b1;
      for (int i = 0; i < 8; i++)
        if (jk_log[first + 8*m + i] !== ops3[m]) ok = 1'b0;
      chk($sformatf("t3_cmd%0d_order", m), ok, 1);
    end
    chk("t3_idle_after", jk_log[first + 48], 2'b00);
    chk("t3_done_count", done_seen - d0, 6);
    chk("t3_err_cnt", err_cnt, 0);

    // 4: forced wrong q after sync
    force_inv = 1'b1;
    step(); chk("t4_err_a", err, 1);
    step(); chk("t4_err_b", err, 1);
    step(); chk("t4_err_c", err, 1);
    force_inv = 1'b0;
    step();
    chk("t4_err_low", err, 0);
    chk("t4_err_cnt", err_cnt, 3);

    // 5: no checking before the first SET/CLEAR
    reset = 1'b1; step(); reset = 1'b0;
    force_inv = 1'b1;
    e0 = err_seen;
    cmd_valid = 1'b1; cmd_op = OP_HOLD; cmd_cnt = 8'd1;
    step();
    cmd_op = OP_TOGGLE; cmd_cnt = 8'd2;
    step();
    cmd_valid = 1'b0;
    n = 0;
    while (busy && n < 50) begin step(); n++; end
    chk("t5_drain_timeout", busy, 0);
    step(); step(); step();
    chk("t5_no_err_pulse", err_seen - e0, 0);
    chk("t5_err_cnt", err_cnt, 0);
    chk("t5_q_toggled", q, 1);
    force_inv = 1'b0;

    // 6: reset in the middle of a long TOGGLE with a command still queued
    cmd_valid = 1'b1; cmd_op = OP_SET; cmd_cnt = 8'd0;
    step();
    cmd_op = OP_TOGGLE; cmd_cnt = 8'd200;
    step();
    cmd_op = OP_CLEAR; cmd_cnt = 8'd0;
    step();
    cmd_valid = 1'b0;
    repeat (8) step();
    force_inv = 1'b1;
    step(); step();
    force_inv = 1'b0;
    step(); step();
    chk("t6_err_cnt_pre", err_cnt, 2);
    chk("t6_busy_pre", busy, 1);
    chk("t6_toggle_drive", {j, k}, 2'b11);
    d0 = done_seen;
    reset = 1'b1;
    step();
    chk("t6_j", j, 0);
    chk("t6_k", k, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ready", cmd_ready, 1);
    chk("t6_err_cnt", err_cnt, 0);
    chk("t6_done", done, 0);
    reset = 1'b0;
    repeat (5) step();
    chk("t6_still_idle", busy, 0);
    chk("t6_no_queued_run", {j, k}, 2'b00);
    chk("t6_no_done", done_seen - d0, 0);

    // 7: maximum count gives 256 drive cycles
    d0 = done_seen; base = jk_log.size();
    cmd_valid = 1'b1; cmd_op = OP_SET; cmd_cnt = 8'd255;
    step();
    cmd_valid = 1'b0;
    n = 0;
    while (busy && n < 400) begin step(); n++; end
    chk("t7_drain_timeout", busy, 0);
    step(); step();
    cnt10 = 0;
    for (int i = base; i < jk_log.size(); i++)
      if (jk_log[i] == 2'b10) cnt10++;
    chk("t7_drive_cycles", cnt10, 256);
    chk("t7_done_count", done_seen - d0, 1);
    chk("t7_q", q, 1);
    chk("t7_err_cnt", err_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
